timing_leak_monitor: RTL and testbench

- Downstream checker for the two-copy constant-time multiplier harness.
- Consumes the shared start pulse and each copy's productDone.
- Measures start-to-done latency of each copy and flags a timing leak when the latencies differ, or when either copy fails to finish.
- Keeps running totals across runs so long random-operand campaigns report a single leak count.

---
 rtl/timing_leak_monitor.sv | 159 +++++++++++++++
 tb/tb_timing_leak_monitor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/timing_leak_monitor.sv
// Start-to-done latency comparator for the two-copy constant-time multiplier harness.
// Flags a timing leak when the copies' latencies differ or a copy never finishes, and keeps campaign totals.
module timing_leak_monitor #(
   parameter int CNT_WIDTH = 16,
   parameter int TIMEOUT   = 1024,
   parameter int RUN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 productDoneOne,
   input  logic                 productDoneTwo,
   output logic [CNT_WIDTH-1:0] cyclesOne,
   output logic [CNT_WIDTH-1:0] cyclesTwo,
   output logic [CNT_WIDTH-1:0] cycleDelta,
   output logic                 timingLeak,
   output logic                 timingLeakDone,
   output logic                 timeout,
   output logic                 busy,
   output logic [RUN_WIDTH-1:0] runCount,
   output logic [RUN_WIDTH-1:0] leakCount
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
   localparam logic [RUN_WIDTH-1:0] RUN_MAX     = '1;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 seen_one_q, seen_one_d;
   logic                 seen_two_q, seen_two_d;
   logic [CNT_WIDTH-1:0] cycles_one_q, cycles_one_d;
   logic [CNT_WIDTH-1:0] cycles_two_q, cycles_two_d;
   logic [CNT_WIDTH-1:0] delta_q, delta_d;
   logic                 leak_q, leak_d;
   logic                 leak_done_q, leak_done_d;
   logic                 timeout_q, timeout_d;
   logic [RUN_WIDTH-1:0] run_cnt_q, run_cnt_d;
   logic [RUN_WIDTH-1:0] leak_cnt_q, leak_cnt_d;

   logic finish;
   logic expired;
   logic leak_now;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         seen_one_q   <= 1'b0;
         seen_two_q   <= 1'b0;
         cycles_one_q <= '0;
         cycles_two_q <= '0;
         delta_q      <= '0;
         leak_q       <= 1'b0;
         leak_done_q  <= 1'b0;
         timeout_q    <= 1'b0;
         run_cnt_q    <= '0;
         leak_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         seen_one_q   <= seen_one_d;
         seen_two_q   <= seen_two_d;
         cycles_one_q <= cycles_one_d;
         cycles_two_q <= cycles_two_d;
         delta_q      <= delta_d;
         leak_q       <= leak_d;
         leak_done_q  <= leak_done_d;
         timeout_q    <= timeout_d;
         run_cnt_q    <= run_cnt_d;
         leak_cnt_q   <= leak_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      seen_one_d   = seen_one_q;
      seen_two_d   = seen_two_q;
      cycles_one_d = cycles_one_q;
      cycles_two_d = cycles_two_q;
      delta_d      = delta_q;
      leak_d       = leak_q;
      leak_done_d  = leak_done_q;
      timeout_d    = timeout_q;
      run_cnt_d    = run_cnt_q;
      leak_cnt_d   = leak_cnt_q;
      finish       = 1'b0;
      expired      = 1'b0;
      leak_now     = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            // Done inputs are deliberately ignored until a start is accepted.
            if (start) begin
               state_d      = RUN;
               cnt_d        = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
               seen_one_d   = 1'b0;
               seen_two_d   = 1'b0;
               cycles_one_d = '0;
               cycles_two_d = '0;
               delta_d      = '0;
               leak_d       = 1'b0;
               leak_done_d  = 1'b0;
               timeout_d    = 1'b0;
            end
         end

         RUN: begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            if (productDoneOne && !seen_one_q) begin
               cycles_one_d = cnt_q;
               seen_one_d   = 1'b1;
            end
            if (productDoneTwo && !seen_two_q) begin
               cycles_two_d = cnt_q;
               seen_two_d   = 1'b1;
            end

            // A done landing exactly on the timeout cycle still completes the run normally.
            if (seen_one_d && seen_two_d) begin
               finish = 1'b1;
            end else if (cnt_q == TIMEOUT_CNT) begin
               finish  = 1'b1;
               expired = 1'b1;
               if (!seen_one_d) cycles_one_d = CNT_MAX;
               if (!seen_two_d) cycles_two_d = CNT_MAX;
            end

            if (finish) begin
               leak_now    = (cycles_one_d != cycles_two_d) || expired;
               state_d     = DONE;
               leak_done_d = 1'b1;
               leak_d      = leak_now;
               timeout_d   = expired;
               delta_d     = (cycles_one_d >= cycles_two_d) ? cycles_one_d - cycles_two_d
                                                            : cycles_two_d - cycles_one_d;
               if (run_cnt_q != RUN_MAX) run_cnt_d = run_cnt_q + 1'b1;
               if (leak_now && (leak_cnt_q != RUN_MAX)) leak_cnt_d = leak_cnt_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign cyclesOne      = cycles_one_q;
   assign cyclesTwo      = cycles_two_q;
   assign cycleDelta     = delta_q;
   assign timingLeak     = leak_q;
   assign timingLeakDone = leak_done_q;
   assign timeout        = timeout_q;
   assign busy           = (state_q == RUN);
   assign runCount       = run_cnt_q;
   assign leakCount      = leak_cnt_q;

endmodule

// File: tb/tb_timing_leak_monitor.sv
// Directed bench for timing_leak_monitor: instance a uses the default TIMEOUT, instance b uses TIMEOUT=16.
// Both share the same stimulus; each scenario checks only the instance it targets.
module tb_timing_leak_monitor;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic done_one;
   logic done_two;

   logic [15:0] c1_a, c2_a, dl_a, rc_a, lc_a;
   logic        lk_a, ld_a, to_a, by_a;
   logic [15:0] c1_b, c2_b, dl_b, rc_b, lc_b;
   logic        lk_b, ld_b, to_b, by_b;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   timing_leak_monitor #(.CNT_WIDTH(16), .TIMEOUT(1024), .RUN_WIDTH(16)) dut_a (
      .clk(clk), .rst(rst), .start(start),
      .productDoneOne(done_one), .productDoneTwo(done_two),
      .cyclesOne(c1_a), .cyclesTwo(c2_a), .cycleDelta(dl_a),
      .timingLeak(lk_a), .timingLeakDone(ld_a), .timeout(to_a), .busy(by_a),
      .runCount(rc_a), .leakCount(lc_a)
   );

   timing_leak_monitor #(.CNT_WIDTH(16), .TIMEOUT(16), .RUN_WIDTH(16)) dut_b (
      .clk(clk), .rst(rst), .start(start),
      .productDoneOne(done_one), .productDoneTwo(done_two),
      .cyclesOne(c1_b), .cyclesTwo(c2_b), .cycleDelta(dl_b),
      .timingLeak(lk_b), .timingLeakDone(ld_b), .timeout(to_b), .busy(by_b),
      .runCount(rc_b), .leakCount(lc_b)
   );

   // Inputs change 1 time unit after a rising edge; outputs are read at that same point.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   // After this returns, the start edge is cycle 0 and the counter reads 1.
   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Cycle c is the c-th edge after the start edge; a done there measures latency c. 0 means never.
   task automatic drive_cycles(input int d1a, input int d1b, input int d2, input int from, input int to);
      for (int c = from; c <= to; c++) begin
         done_one = (c == d1a) || (c == d1b);
         done_two = (c == d2);
         tick();
      end
      done_one = 1'b0;
      done_two = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (c1_a !== 16'd0 || c2_a !== 16'd0 || dl_a !== 16'd0) begin failed++; $display("FAIL reset_cycles got %0d/%0d/%0d exp 0/0/0", c1_a, c2_a, dl_a); end
      tests++; if ({lk_a, ld_a, to_a, by_a} !== 4'b0000) begin failed++; $display("FAIL reset_flags got %b exp 0000", {lk_a, ld_a, to_a, by_a}); end
      tests++; if (rc_a !== 16'd0 || lc_a !== 16'd0) begin failed++; $display("FAIL reset_totals got %0d/%0d exp 0/0", rc_a, lc_a); end
   endtask

   task automatic test_equal();
      start_run();
      tests++; if (by_a !== 1'b1) begin failed++; $display("FAIL equal_busy got %b exp 1", by_a); end
      drive_cycles(0, 0, 0, 1, 129);
      tests++; if (ld_a !== 1'b0 || by_a !== 1'b1) begin failed++; $display("FAIL equal_early got done=%b busy=%b exp 0/1", ld_a, by_a); end
      drive_cycles(130, 0, 130, 130, 130);
      tests++; if (c1_a !== 16'd130 || c2_a !== 16'd130) begin failed++; $display("FAIL equal_cycles got %0d/%0d exp 130/130", c1_a, c2_a); end
      tests++; if (dl_a !== 16'd0 || lk_a !== 1'b0 || ld_a !== 1'b1 || by_a !== 1'b0) begin failed++; $display("FAIL equal_result got delta=%0d leak=%b done=%b busy=%b exp 0/0/1/0", dl_a, lk_a, ld_a, by_a); end
      tests++; if (rc_a !== 16'd1 || lc_a !== 16'd0) begin failed++; $display("FAIL equal_totals got %0d/%0d exp 1/0", rc_a, lc_a); end
      tick(); tick();
      tests++; if (ld_a !== 1'b1 || c1_a !== 16'd130 || rc_a !== 16'd1) begin failed++; $display("FAIL equal_hold got done=%b c1=%0d rc=%0d exp 1/130/1", ld_a, c1_a, rc_a); end
   endtask

   task automatic test_unequal();
      start_run();
      tests++; if (ld_a !== 1'b0 || c1_a !== 16'd0) begin failed++; $display("FAIL unequal_clear got done=%b c1=%0d exp 0/0", ld_a, c1_a); end
      drive_cycles(128, 0, 131, 1, 128);
      tests++; if (c1_a !== 16'd128 || by_a !== 1'b1 || ld_a !== 1'b0) begin failed++; $display("FAIL unequal_first got c1=%0d busy=%b done=%b exp 128/1/0", c1_a, by_a, ld_a); end
      drive_cycles(128, 0, 131, 129, 131);
      tests++; if (c1_a !== 16'd128 || c2_a !== 16'd131 || dl_a !== 16'd3) begin failed++; $display("FAIL unequal_cycles got %0d/%0d/%0d exp 128/131/3", c1_a, c2_a, dl_a); end
      tests++; if (lk_a !== 1'b1 || ld_a !== 1'b1 || to_a !== 1'b0) begin failed++; $display("FAIL unequal_flags got leak=%b done=%b to=%b exp 1/1/0", lk_a, ld_a, to_a); end
      tests++; if (rc_a !== 16'd2 || lc_a !== 16'd1) begin failed++; $display("FAIL unequal_totals got %0d/%0d exp 2/1", rc_a, lc_a); end
   endtask

   // Instance b times out; instance a meanwhile sees a second start mid-run and a re-pulsed doneOne.
   task automatic test_timeout();
      do_reset();
      start_run();
      drive_cycles(5, 0, 0, 1, 15);
      tests++; if (ld_b !== 1'b0 || by_b !== 1'b1 || c1_b !== 16'd5) begin failed++; $display("FAIL timeout_pre got done=%b busy=%b c1=%0d exp 0/1/5", ld_b, by_b, c1_b); end
      drive_cycles(5, 0, 0, 16, 16);
      tests++; if (to_b !== 1'b1 || lk_b !== 1'b1 || ld_b !== 1'b1 || by_b !== 1'b0) begin failed++; $display("FAIL timeout_flags got to=%b leak=%b done=%b busy=%b exp 1/1/1/0", to_b, lk_b, ld_b, by_b); end
      tests++; if (c1_b !== 16'd5 || c2_b !== 16'hFFFF || dl_b !== 16'hFFFA) begin failed++; $display("FAIL timeout_cycles got %h/%h/%h exp 0005/ffff/fffa", c1_b, c2_b, dl_b); end
      tests++; if (rc_b !== 16'd1 || lc_b !== 16'd1) begin failed++; $display("FAIL timeout_totals got %0d/%0d exp 1/1", rc_b, lc_b); end
      start_run();
      drive_cycles(5, 0, 16, 1, 16);
      tests++; if (to_b !== 1'b0 || lk_b !== 1'b1 || ld_b !== 1'b1) begin failed++; $display("FAIL edge_flags got to=%b leak=%b done=%b exp 0/1/1", to_b, lk_b, ld_b); end
      tests++; if (c1_b !== 16'd5 || c2_b !== 16'd16 || dl_b !== 16'd11) begin failed++; $display("FAIL edge_cycles got %0d/%0d/%0d exp 5/16/11", c1_b, c2_b, dl_b); end
      tests++; if (rc_b !== 16'd2 || lc_b !== 16'd2) begin failed++; $display("FAIL edge_totals got %0d/%0d exp 2/2", rc_b, lc_b); end
      // a: first start at edge 0, ignored start at edge 17, doneTwo at edge 33.
      tests++; if (c1_a !== 16'd5 || c2_a !== 16'd33 || dl_a !== 16'd28) begin failed++; $display("FAIL start_in_run got %0d/%0d/%0d exp 5/33/28", c1_a, c2_a, dl_a); end
      tests++; if (ld_a !== 1'b1 || lk_a !== 1'b1 || rc_a !== 16'd1) begin failed++; $display("FAIL start_in_run_flags got done=%b leak=%b rc=%0d exp 1/1/1", ld_a, lk_a, rc_a); end
   endtask

   task automatic test_glitch();
      do_reset();
      done_one = 1'b1;
      done_two = 1'b1;
      tick(); tick(); tick();
      done_one = 1'b0;
      done_two = 1'b0;
      tests++; if (by_a !== 1'b0 || ld_a !== 1'b0 || c1_a !== 16'd0 || c2_a !== 16'd0 || rc_a !== 16'd0) begin failed++; $display("FAIL idle_done got busy=%b done=%b c=%0d/%0d rc=%0d exp 0/0/0/0/0", by_a, ld_a, c1_a, c2_a, rc_a); end
      start_run();
      drive_cycles(10, 20, 25, 1, 25);
      tests++; if (c1_a !== 16'd10 || c2_a !== 16'd25 || dl_a !== 16'd15) begin failed++; $display("FAIL repulse got %0d/%0d/%0d exp 10/25/15", c1_a, c2_a, dl_a); end
      tests++; if (ld_a !== 1'b1 || lk_a !== 1'b1 || lc_a !== 16'd1) begin failed++; $display("FAIL repulse_flags got done=%b leak=%b lc=%0d exp 1/1/1", ld_a, lk_a, lc_a); end
   endtask

   task automatic test_reset_mid();
      start_run();
      drive_cycles(0, 0, 0, 1, 49);
      tests++; if (by_a !== 1'b1) begin failed++; $display("FAIL mid_busy got %b exp 1", by_a); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tests++; if ({lk_a, ld_a, to_a, by_a} !== 4'b0000 || c1_a !== 16'd0 || dl_a !== 16'd0) begin failed++; $display("FAIL mid_reset got flags=%b c1=%0d delta=%0d exp 0000/0/0", {lk_a, ld_a, to_a, by_a}, c1_a, dl_a); end
      tests++; if (rc_a !== 16'd0 || lc_a !== 16'd0) begin failed++; $display("FAIL mid_totals got %0d/%0d exp 0/0", rc_a, lc_a); end
      start_run();
      drive_cycles(7, 0, 7, 1, 7);
      tests++; if (c1_a !== 16'd7 || c2_a !== 16'd7 || lk_a !== 1'b0 || rc_a !== 16'd1) begin failed++; $display("FAIL fresh_run got %0d/%0d leak=%b rc=%0d exp 7/7/0/1", c1_a, c2_a, lk_a, rc_a); end
   endtask

   task automatic test_back_to_back();
      start_run();
      tests++; if (ld_a !== 1'b0 || by_a !== 1'b1 || c1_a !== 16'd0) begin failed++; $display("FAIL b2b_drop got done=%b busy=%b c1=%0d exp 0/1/0", ld_a, by_a, c1_a); end
      drive_cycles(1, 0, 1, 1, 1);
      tests++; if (c1_a !== 16'd1 || c2_a !== 16'd1 || lk_a !== 1'b0 || ld_a !== 1'b1) begin failed++; $display("FAIL b2b_lat1 got %0d/%0d leak=%b done=%b exp 1/1/0/1", c1_a, c2_a, lk_a, ld_a); end
      start_run();
      drive_cycles(4, 0, 2, 1, 4);
      tests++; if (c1_a !== 16'd4 || c2_a !== 16'd2 || dl_a !== 16'd2 || lk_a !== 1'b1) begin failed++; $display("FAIL b2b_third got %0d/%0d/%0d leak=%b exp 4/2/2/1", c1_a, c2_a, dl_a, lk_a); end
      tests++; if (rc_a !== 16'd3 || lc_a !== 16'd1) begin failed++; $display("FAIL b2b_totals got %0d/%0d exp 3/1", rc_a, lc_a); end
   endtask

   initial begin
      rst      = 1'b0;
      start    = 1'b0;
      done_one = 1'b0;
      done_two = 1'b0;
      tick();
      test_reset();
      test_equal();
      test_unequal();
      test_timeout();
      test_glitch();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
